// File: rtl/nn_pkg.sv
// nn_pkg: Q8.8 data format, layer sequencer FSM encoding and sizing helpers
package nn_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  typedef enum logic [2:0] {IDLE, PRIME, STREAM, LAST, WAIT, WRITE, FIN} state_t;
  // address width for a count of n, never narrower than one bit
  function automatic int aw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic signed [DATA_W-1:0] q88(input int whole);
    return DATA_W'(whole <<< FRAC_W);
  endfunction
endpackage

// File: rtl/layer_addr_gen.sv
// layer_addr_gen: element index i, output index j and running weight address
module layer_addr_gen #(
  parameter int N = 4,
  parameter int M = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          inc,
  input  logic                          i_clr,
  input  logic                          j_inc,
  output logic [nn_pkg::aw(N)-1:0]      i,
  output logic [nn_pkg::aw(M)-1:0]      j,
  output logic [nn_pkg::aw(N*M)-1:0]    w_addr,
  output logic                          i_last,
  output logic                          j_last
);
  import nn_pkg::*;
  localparam int IW = aw(N);
  localparam int JW = aw(M);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
      w_addr <= '0;
    end else if (clr) begin
      i <= '0;
      j <= '0;
      w_addr <= '0;
    end else begin
      if (i_clr) i <= '0;
      else if (inc) i <= i + 1'b1;
      if (inc) w_addr <= w_addr + 1'b1;
      if (j_inc) j <= j + 1'b1;
    end
  end
  assign i_last = i == IW'(N - 1);
  assign j_last = j == JW'(M - 1);
endmodule

// File: rtl/neuron_layer_seq.sv
// neuron_layer_seq: drives one shared neuron through all M outputs of a dense layer
module neuron_layer_seq #(
  parameter int N = 4,
  parameter int M = 2,
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout,
  output logic [nn_pkg::aw(N)-1:0]      x_rd_addr,
  input  logic [DATA_W-1:0]             x_rd_data,
  output logic [nn_pkg::aw(N*M)-1:0]    w_rd_addr,
  input  logic [DATA_W-1:0]             w_rd_data,
  output logic [nn_pkg::aw(M)-1:0]      b_rd_addr,
  input  logic [DATA_W-1:0]             b_rd_data,
  output logic                          neuron_start,
  output logic [DATA_W-1:0]             neuron_x,
  output logic [DATA_W-1:0]             neuron_w,
  output logic [DATA_W-1:0]             neuron_b,
  input  logic [DATA_W-1:0]             neuron_act,
  input  logic                          neuron_done,
  output logic                          y_wr_en,
  output logic [nn_pkg::aw(M)-1:0]      y_wr_addr,
  output logic [DATA_W-1:0]             y_wr_data
);
  import nn_pkg::*;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [TW-1:0] timer;
  logic [aw(N)-1:0] i;
  logic [aw(M)-1:0] j;
  logic [aw(N*M)-1:0] w_addr;
  logic i_last, j_last;
  layer_addr_gen #(.N(N), .M(M)) u_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == IDLE && start),
    .inc    (state == PRIME || state == STREAM),
    .i_clr  (state == LAST),
    .j_inc  (state == WRITE && !j_last),
    .i      (i),
    .j      (j),
    .w_addr (w_addr),
    .i_last (i_last),
    .j_last (j_last)
  );
  assign x_rd_addr = i;
  assign w_rd_addr = w_addr;
  assign b_rd_addr = j;
  assign neuron_x = x_rd_data;
  assign neuron_w = w_rd_data;
  assign neuron_b = b_rd_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_timeout <= 1'b0;
      neuron_start <= 1'b0;
      y_wr_en <= 1'b0;
      y_wr_addr <= '0;
      y_wr_data <= '0;
    end else begin
      // element 0 is on the RAM outputs exactly one cycle after PRIME issued address 0
      neuron_start <= state == PRIME;
      done <= 1'b0;
      y_wr_en <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= PRIME;
          busy <= 1'b1;
          err_timeout <= 1'b0;
        end
        PRIME, STREAM: state <= i_last ? LAST : STREAM;
        LAST: begin
          state <= WAIT;
          timer <= '0;
        end
        WAIT: if (neuron_done) begin
          state <= WRITE;
          y_wr_en <= 1'b1;
          y_wr_addr <= j;
          y_wr_data <= neuron_act;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state <= FIN;
          done <= 1'b1;
          err_timeout <= 1'b1;
        end else timer <= timer + 1'b1;
        WRITE: if (j_last) begin
          state <= FIN;
          done <= 1'b1;
        end else state <= PRIME;
        FIN: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_layer_seq.sv
// tb_neuron_layer_seq: directed and random layer runs against RAM and neuron models
module tb_neuron_layer_seq;
  import nn_pkg::*;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  int total = 0, passed = 0, failed = 0;

  logic start4 = 0, busy4, done4, err4, ns4, nd4 = 0, ywe4;
  logic [1:0] xa4;
  logic [2:0] wa4;
  logic [0:0] ba4, ywa4;
  logic [15:0] xd4, wd4, bd4, nx4, nw4, nb4, na4 = 0, ywd4;
  neuron_layer_seq #(.N(4), .M(2)) d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4), .err_timeout(err4),
    .x_rd_addr(xa4), .x_rd_data(xd4), .w_rd_addr(wa4), .w_rd_data(wd4), .b_rd_addr(ba4), .b_rd_data(bd4),
    .neuron_start(ns4), .neuron_x(nx4), .neuron_w(nw4), .neuron_b(nb4), .neuron_act(na4), .neuron_done(nd4),
    .y_wr_en(ywe4), .y_wr_addr(ywa4), .y_wr_data(ywd4));

  logic start1 = 0, busy1, done1, err1, ns1, nd1 = 0, ywe1;
  logic [0:0] xa1;
  logic [1:0] wa1, ba1, ywa1;
  logic [15:0] xd1, wd1, bd1, nx1, nw1, nb1, na1 = 0, ywd1;
  neuron_layer_seq #(.N(1), .M(3)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .err_timeout(err1),
    .x_rd_addr(xa1), .x_rd_data(xd1), .w_rd_addr(wa1), .w_rd_data(wd1), .b_rd_addr(ba1), .b_rd_data(bd1),
    .neuron_start(ns1), .neuron_x(nx1), .neuron_w(nw1), .neuron_b(nb1), .neuron_act(na1), .neuron_done(nd1),
    .y_wr_en(ywe1), .y_wr_addr(ywa1), .y_wr_data(ywd1));

  logic [15:0] x4m [4], w4m [8], b4m [2], y4 [2];
  logic [15:0] x1m [2], w1m [4], b1m [4], y1 [4];
  int k4 = 0, acc4 = 0, wcnt4 = 0, dcnt4 = 0, scnt4 = 0, p4;
  int k1 = 0, acc1 = 0, wcnt1 = 0, scnt1 = 0, p1;
  bit dead4 = 0;
  logic [2:0] wprev4 = 0;
  logic [2:0] wseen4 [$];
  logic [15:0] sw4 [$], sw1 [$];
  assign p4 = int'($signed(nx4)) * int'($signed(nw4));
  assign p1 = int'($signed(nx1)) * int'($signed(nw1));

  // sync-read RAMs, y capture and a behavioural neuron (done one cycle after the last element)
  always @(posedge clk) begin
    xd4 <= x4m[xa4];
    wd4 <= w4m[wa4];
    bd4 <= b4m[ba4];
    wprev4 <= wa4;
    if (ywe4) begin
      y4[ywa4] <= ywd4;
      wcnt4 <= wcnt4 + 1;
    end
    if (done4) dcnt4 <= dcnt4 + 1;
    if (ns4 || (k4 > 0 && k4 < 4)) wseen4.push_back(wprev4);
    if (ns4) begin
      sw4.push_back(nw4);
      scnt4 <= scnt4 + 1;
      acc4 <= p4;
      k4 <= 1;
      nd4 <= 1'b0;
    end else if (k4 > 0 && k4 < 4) begin
      acc4 <= acc4 + p4;
      k4 <= k4 + 1;
    end else if (k4 == 4) begin
      k4 <= 0;
      if (!dead4) begin
        nd4 <= 1'b1;
        na4 <= 16'((acc4 >>> 8) + int'($signed(nb4)));
      end
    end
  end

  always @(posedge clk) begin
    xd1 <= x1m[xa1];
    wd1 <= w1m[wa1];
    bd1 <= b1m[ba1];
    if (ywe1) begin
      y1[ywa1] <= ywd1;
      wcnt1 <= wcnt1 + 1;
    end
    if (ns1) begin
      sw1.push_back(nw1);
      scnt1 <= scnt1 + 1;
      acc1 <= p1;
      k1 <= 1;
      nd1 <= 1'b0;
    end else if (k1 == 1) begin
      k1 <= 0;
      nd1 <= 1'b1;
      na1 <= 16'((acc1 >>> 8) + int'($signed(nb1)));
    end
  end

  function automatic logic [15:0] ref4(input int j);
    int acc = 0;
    for (int i = 0; i < 4; i++) acc += int'($signed(x4m[i])) * int'($signed(w4m[j*4+i]));
    return 16'((acc >>> 8) + int'($signed(b4m[j])));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_directed();
    x4m = '{q88(1), q88(2), q88(3), q88(4)};
    w4m = '{16'h0080, 16'h0180, 16'h0280, 16'h0380, 16'hFF00, 16'h0000, 16'h0100, 16'h0040};
    b4m = '{q88(5), q88(0)};
  endtask

  // called at a negedge; returns at the negedge after the FIN cycle
  task automatic run4(input int mid, input bit fin_start, output int cyc, output logic e1);
    start4 = 1;
    @(negedge clk);
    start4 = 0;
    cyc = 1;
    e1 = err4;
    while (!done4 && cyc < 500) begin
      start4 = (cyc == mid);
      @(negedge clk);
      cyc++;
    end
    chk("done_within_bound", 32'(done4), 1);
    start4 = fin_start;
    @(negedge clk);
    start4 = 0;
  endtask

  initial begin
    int cyc, cyc_clean, w0, d0, s0, q0;
    logic e1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_done", 32'(done4), 0);
    chk("rst_err", 32'(err4), 0);
    chk("rst_nstart", 32'(ns4), 0);
    chk("rst_ywe", 32'(ywe4), 0);
    chk("rst_ywa", 32'(ywa4), 0);
    chk("rst_ywd", 32'(ywd4), 0);
    rst_n = 1;
    @(negedge clk);

    load_directed();
    w0 = wcnt4; d0 = dcnt4; s0 = scnt4; q0 = wseen4.size();
    run4(0, 1, cyc_clean, e1);
    chk("dir_y0", 32'(y4[0]), 32'h1E00);
    chk("dir_y1", 32'(y4[1]), 32'h0300);
    chk("dir_writes", wcnt4 - w0, 2);
    chk("dir_done_pulses", dcnt4 - d0, 1);
    chk("dir_nstart_count", scnt4 - s0, 2);
    chk("nstart_elem0_j0", 32'(sw4[s0]), 32'h0080);
    chk("nstart_elem0_j1", 32'(sw4[s0+1]), 32'hFF00);
    chk("w_addr_count", wseen4.size() - q0, 8);
    for (int e = 0; e < 8; e++) chk("w_addr_seq", 32'(wseen4[q0+e]), e);
    chk("fin_start_ignored", 32'(busy4), 0);

    w0 = wcnt4; d0 = dcnt4;
    run4(5, 0, cyc, e1);
    chk("mid_start_cycles", cyc, cyc_clean);
    chk("mid_start_y0", 32'(y4[0]), 32'h1E00);
    chk("mid_start_y1", 32'(y4[1]), 32'h0300);
    chk("mid_start_writes", wcnt4 - w0, 2);
    chk("mid_start_done", dcnt4 - d0, 1);

    repeat (3) begin
      for (int i = 0; i < 4; i++) x4m[i] = 16'($urandom_range(0, 1023)) - 16'd512;
      for (int i = 0; i < 8; i++) w4m[i] = 16'($urandom_range(0, 1023)) - 16'd512;
      for (int i = 0; i < 2; i++) b4m[i] = 16'($urandom_range(0, 1023)) - 16'd512;
      w0 = wcnt4;
      run4(0, 0, cyc, e1);
      chk("rand_y0", 32'(y4[0]), 32'(ref4(0)));
      chk("rand_y1", 32'(y4[1]), 32'(ref4(1)));
      chk("rand_writes", wcnt4 - w0, 2);
    end

    dead4 = 1;
    w0 = wcnt4; d0 = dcnt4;
    run4(0, 0, cyc, e1);
    // PRIME + (N-1) STREAM + LAST + TIMEOUT WAIT cycles, then the FIN cycle
    chk("timeout_cycles", cyc, 1 + 3 + 1 + 64 + 1);
    chk("timeout_err", 32'(err4), 1);
    chk("timeout_no_write", wcnt4 - w0, 0);
    chk("timeout_done", dcnt4 - d0, 1);
    chk("timeout_busy_low", 32'(busy4), 0);
    dead4 = 0;
    load_directed();
    run4(0, 0, cyc, e1);
    chk("err_cleared_on_start", 32'(e1), 0);
    chk("err_stays_clear", 32'(err4), 0);
    chk("post_timeout_y0", 32'(y4[0]), 32'h1E00);

    w0 = wcnt4;
    start4 = 1;
    @(negedge clk);
    start4 = 0;
    for (int c = 0; c < 100 && wcnt4 == w0; c++) @(negedge clk);
    chk("rst_wait_j0_write", wcnt4 - w0, 1);
    @(negedge clk);
    chk("pre_rst_nstart_j1", 32'(ns4), 1);
    rst_n = 0;
    #1;
    chk("async_rst_busy", 32'(busy4), 0);
    chk("async_rst_nstart", 32'(ns4), 0);
    chk("async_rst_ywe", 32'(ywe4), 0);
    chk("async_rst_ywd", 32'(ywd4), 0);
    chk("async_rst_waddr", 32'(wa4), 0);
    repeat (3) @(negedge clk);
    chk("rst_no_extra_write", wcnt4 - w0, 1);
    chk("rst_y0_kept", 32'(y4[0]), 32'h1E00);
    rst_n = 1;
    @(negedge clk);
    w0 = wcnt4;
    run4(0, 0, cyc, e1);
    chk("rerun_y0", 32'(y4[0]), 32'h1E00);
    chk("rerun_y1", 32'(y4[1]), 32'h0300);
    chk("rerun_writes", wcnt4 - w0, 2);

    x1m = '{q88(2), 16'h0000};
    w1m = '{16'h0100, 16'hFF80, 16'h0000, 16'h0000};
    b1m = '{16'h0000, 16'h0100, 16'h0000, 16'h0000};
    w0 = wcnt1; s0 = scnt1;
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    for (int c = 0; c < 200 && !done1; c++) @(negedge clk);
    chk("n1_done", 32'(done1), 1);
    @(negedge clk);
    chk("n1_y0", 32'(y1[0]), 32'h0200);
    chk("n1_y1", 32'(y1[1]), 32'h0000);
    chk("n1_y2", 32'(y1[2]), 32'h0000);
    chk("n1_writes", wcnt1 - w0, 3);
    chk("n1_nstart_count", scnt1 - s0, 3);
    chk("n1_nstart_w1", 32'(sw1[s0+1]), 32'hFF80);
    chk("n1_busy_low", 32'(busy1), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
